// File: rtl/mem_ctrl_pkg.sv
// Shared FSM encoding and timeout constants for mem_access_ctrl.
// The optional watchdog is enabled by defining MEM_TIMEOUT_EN.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd255;
  localparam int unsigned CNT_W              = 32'd8;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// ACCESS-state watchdog: counts un-acked ACCESS cycles and flags the last one.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LIMIT - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle whose increment would reach LIMIT.
  assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: IDLE -> ACCESS -> DONE handshake.
// Define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without ack.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] Addr_in,
  input  logic [31:0] StoreData_in,
  output logic        MemReq_out,
  output logic        MemWe_out,
  output logic [31:0] MemAddr_out,
  output logic [31:0] MemWdata_out,
  input  logic        MemAck_in,
  input  logic [31:0] MemRdata_in,
  output logic        Stall_out,
  output logic [31:0] LoadData_out,
  output logic        LoadValid_out,
  output logic        Err_out
);

  if (TIMEOUT_CYCLES < 32'd1 || TIMEOUT_CYCLES > 32'd255) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT_CYCLES must be within 1..255");
  end

  state_e      state_q;
  state_e      state_d;
  logic        req_q;
  logic        req_d;
  logic        we_q;
  logic        we_d;
  logic [31:0] addr_q;
  logic [31:0] addr_d;
  logic [31:0] wdata_q;
  logic [31:0] wdata_d;
  logic [31:0] ldata_q;
  logic [31:0] ldata_d;
  logic        lvalid_q;
  logic        lvalid_d;
  logic        mem_op_s;
  logic        timeout_s;

  assign mem_op_s = is_mem_op(MemRead_in, MemWrite_in);

`ifdef MEM_TIMEOUT_EN
  logic cnt_clr_s;
  logic cnt_en_s;
  logic err_q;

  assign cnt_clr_s = (state_q == ST_IDLE) && mem_op_s;
  assign cnt_en_s  = (state_q == ST_ACCESS) && !MemAck_in;

  mem_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (cnt_clr_s),
    .en_i     (cnt_en_s),
    .expired_o(timeout_s)
  );

  // Expiry already excludes ack cycles, so an ack on the last cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_s;
    end
  end

  assign Err_out = err_q;
`else
  assign timeout_s = 1'b0;
  assign Err_out   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (MemAck_in || timeout_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      // DONE never looks at the request inputs: the same instruction is still in EX/MEM.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Stall_out = 1'b0;
    if (rst) begin
      Stall_out = mem_op_s;
    end else begin
      case (state_q)
        ST_IDLE:   Stall_out = mem_op_s;
        ST_ACCESS: Stall_out = 1'b1;
        ST_DONE:   Stall_out = 1'b0;
        default:   Stall_out = 1'b0;
      endcase
    end
  end

  always_comb begin
    req_d    = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ldata_d  = ldata_q;
    lvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s) begin
          req_d   = 1'b1;
          we_d    = MemWrite_in;
          addr_d  = Addr_in;
          wdata_d = StoreData_in;
        end else begin
          req_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (MemAck_in) begin
          req_d = 1'b0;
          if (!we_q) begin
            ldata_d  = MemRdata_in;
            lvalid_d = 1'b1;
          end else begin
            ldata_d = ldata_q;
          end
        end else if (timeout_s) begin
          req_d   = 1'b0;
          ldata_d = '0;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DONE: req_d = 1'b0;
      default: req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ldata_q  <= '0;
      lvalid_q <= 1'b0;
    end else begin
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
    end
  end

  assign MemReq_out    = req_q;
  assign MemWe_out     = we_q;
  assign MemAddr_out   = addr_q;
  assign MemWdata_out  = wdata_q;
  assign LoadData_out  = ldata_q;
  assign LoadValid_out = lvalid_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level reference model with random stimulus.
module tb_mem_access_ctrl;

  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int MAXN = TO;
`else
  localparam int MAXN = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in;
  logic [31:0] Addr_in, StoreData_in;
  logic        MemReq_out, MemWe_out;
  logic [31:0] MemAddr_out, MemWdata_out;
  logic        MemAck_in;
  logic [31:0] MemRdata_in;
  logic        Stall_out;
  logic [31:0] LoadData_out;
  logic        LoadValid_out, Err_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_ldata = 32'h0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Addr_in(Addr_in), .StoreData_in(StoreData_in),
    .MemReq_out(MemReq_out), .MemWe_out(MemWe_out),
    .MemAddr_out(MemAddr_out), .MemWdata_out(MemWdata_out),
    .MemAck_in(MemAck_in), .MemRdata_in(MemRdata_in),
    .Stall_out(Stall_out), .LoadData_out(LoadData_out),
    .LoadValid_out(LoadValid_out), .Err_out(Err_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; MemRead_in = 1'b0; MemWrite_in = 1'b0; MemAck_in = 1'b0;
    Addr_in = 32'h0; StoreData_in = 32'h0; MemRdata_in = 32'h0;
    step(); step();
    n_checks++;
    if ({MemReq_out, MemWe_out, LoadValid_out, Err_out, Stall_out} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req/we/lv/err/stall=%b required 00000",
               {MemReq_out, MemWe_out, LoadValid_out, Err_out, Stall_out});
    end
    n_checks++;
    if ({MemAddr_out, MemWdata_out, LoadData_out} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h ldata=%h required all 0",
               MemAddr_out, MemWdata_out, LoadData_out);
    end
    MemRead_in = 1'b1;
    #1;
    n_checks++;
    if (Stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall: got %b required 1", Stall_out);
    end
    MemRead_in = 1'b0;
    step();
    rst = 1'b0;
    exp_ldata = 32'h0;
    step();
  endtask

  // One memory instruction held in EX/MEM until released; n_ack=0 means never ack.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int n_ack,
                         input string name);
    int  k = 0, stalls = 0, reqs = 0, cyc = 0, lv_seen = 0;
    bit  done = 0;
    bit  tmo;
    bit  is_load;
    int  exp_n;
`ifdef MEM_TIMEOUT_EN
    tmo = (n_ack == 0) || (n_ack > TO);
`else
    tmo = 1'b0;
`endif
    exp_n   = tmo ? TO : n_ack;
    is_load = rd && !wr;
    MemRead_in = rd; MemWrite_in = wr; Addr_in = addr; StoreData_in = wd;
    while (!done && cyc < 600) begin
      cyc++;
      if (MemReq_out === 1'b1) begin
        k++;
        MemAck_in   = (k == n_ack);
        MemRdata_in = (k == n_ack) ? rdata : $urandom;
      end else begin
        MemAck_in   = 1'($urandom_range(0, 1));
        MemRdata_in = $urandom;
      end
      #1;
      if (LoadValid_out === 1'b1) lv_seen++;
      if (Stall_out === 1'b1) stalls++;
      if (MemReq_out === 1'b1) begin
        reqs++;
        n_checks++;
        if (MemWe_out !== wr || MemAddr_out !== addr || MemWdata_out !== wd) begin
          n_fail++;
          $display("FAIL %s_burst: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                   name, MemWe_out, MemAddr_out, MemWdata_out, wr, addr, wd);
        end
      end else if (Stall_out !== 1'b1 && stalls > 0) begin
        done = 1;
        if (tmo) exp_ldata = 32'h0;
        else if (is_load) exp_ldata = rdata;
        n_checks++;
        if (LoadValid_out !== (is_load && !tmo) || LoadData_out !== exp_ldata ||
            Err_out !== tmo) begin
          n_fail++;
          $display("FAIL %s_done: lv=%b ldata=%h err=%b required lv=%b ldata=%h err=%b",
                   name, LoadValid_out, LoadData_out, Err_out, is_load && !tmo, exp_ldata, tmo);
        end
      end
      step();
    end
    MemAck_in = 1'b0;
    MemRead_in = 1'b0; MemWrite_in = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_complete: no DONE within 600 cycles, required completion", name);
    end
    n_checks++;
    if (stalls != exp_n + 1 || reqs != exp_n) begin
      n_fail++;
      $display("FAIL %s_latency: stalls=%0d reqs=%0d required stalls=%0d reqs=%0d",
               name, stalls, reqs, exp_n + 1, exp_n);
    end
    n_checks++;
    if (MemReq_out !== 1'b0 || LoadValid_out !== 1'b0 || Err_out !== 1'b0 ||
        lv_seen != ((is_load && !tmo) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_after: req=%b lv=%b err=%b pulses=%0d required 0 0 0 %0d",
               name, MemReq_out, LoadValid_out, Err_out, lv_seen, (is_load && !tmo) ? 1 : 0);
    end
  endtask

  task automatic test_nonmem();
    MemRead_in = 1'b0; MemWrite_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Addr_in = $urandom; StoreData_in = $urandom;
      MemAck_in = 1'($urandom_range(0, 1)); MemRdata_in = $urandom;
      #1;
      n_checks++;
      if (Stall_out !== 1'b0 || MemReq_out !== 1'b0 || LoadValid_out !== 1'b0 ||
          LoadData_out !== exp_ldata) begin
        n_fail++;
        $display("FAIL nonmem: stall=%b req=%b lv=%b ldata=%h required 0 0 0 %h",
                 Stall_out, MemReq_out, LoadValid_out, LoadData_out, exp_ldata);
      end
      step();
    end
    MemAck_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 2, "b2b_load");
    run_txn(1'b0, 1'b1, 32'h0000_0204, 32'hA5A5_5A5A, 32'h0, 1, "b2b_store");
  endtask

  task automatic test_reset_mid_access();
    MemRead_in = 1'b1; MemWrite_in = 1'b0; Addr_in = 32'h0000_0300; StoreData_in = 32'h0;
    MemAck_in = 1'b0;
    step();
    step();
    n_checks++;
    if (MemReq_out !== 1'b1 || Stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: req=%b stall=%b required 1 1", MemReq_out, Stall_out);
    end
    rst = 1'b1;
    step();
    MemRead_in = 1'b0;
    #1;
    n_checks++;
    if ({MemReq_out, MemWe_out, LoadValid_out, Err_out, Stall_out} !== 5'b0 ||
        {MemAddr_out, MemWdata_out, LoadData_out} !== 96'h0) begin
      n_fail++;
      $display("FAIL midrst_post: req=%b we=%b lv=%b err=%b stall=%b addr=%h required all 0",
               MemReq_out, MemWe_out, LoadValid_out, Err_out, Stall_out, MemAddr_out);
    end
    rst = 1'b0;
    exp_ldata = 32'h0;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic rd, wr;
      int   sel = $urandom_range(0, 2);
      rd = (sel != 1);
      wr = (sel != 0);
      run_txn(rd, wr, $urandom, $urandom, $urandom, $urandom_range(1, MAXN), "rand");
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h1111_2222, 0, "timeout");
    run_txn(1'b1, 1'b0, 32'h0000_0504, 32'h0, 32'h3333_4444, TO, "ack_at_expiry");
`else
    run_txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h1111_2222, 9, "long_wait");
`endif
  endtask

  initial begin
    test_reset();
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, "load");
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0BAD_0BAD, 3, "store");
    test_nonmem();
    test_back_to_back();
    run_txn(1'b1, 1'b1, 32'h0000_0080, 32'h7777_8888, 32'h9999_AAAA, 2, "both");
    test_reset_mid_access();
    test_timeout();
    test_random();
    test_nonmem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum ACCESS-state cycles before abort (range 1..255); used only with MEM_TIMEOUT_EN.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 MemRead_in  input  1  load pending in the EX/MEM pipeline register.
REQ-005 MemWrite_in  input  1  store pending in the EX/MEM pipeline register.
REQ-006 Addr_in  input  32  access address (EX/MEM ALU result).
REQ-007 StoreData_in  input  32  store data (EX/MEM store data).
REQ-008 MemReq_out  output  1  request to data memory, registered.
REQ-009 MemWe_out  output  1  1=write, 0=read; valid while MemReq_out=1.
REQ-010 MemAddr_out  output  32  latched address.
REQ-011 MemWdata_out  output  32  latched store data.
REQ-012 MemAck_in  input  1  memory completion; sampled only in ACCESS.
REQ-013 MemRdata_in  input  32  read data; valid when MemAck_in=1.
REQ-014 Stall_out  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; combinational.
REQ-015 LoadData_out  output  32  registered load result.
REQ-016 LoadValid_out  output  1  one-cycle pulse: LoadData_out valid.
REQ-017 Err_out  output  1  one-cycle pulse: timeout abort.

Function
REQ-018 FSM states IDLE, ACCESS, DONE shall be the only states.
REQ-019 IDLE: if MemRead_in|MemWrite_in, latch Addr_in, StoreData_in and MemWe (=MemWrite_in) and go to ACCESS; otherwise remain in IDLE.
REQ-020 MemRead_in and MemWrite_in both high: write priority (MemWe=1), no load pulse.
REQ-021 ACCESS: MemReq_out=1; on MemAck_in=1 go to DONE, MemReq_out low on the next cycle.
REQ-022 On the ack cycle of a read, LoadData_out<=MemRdata_in; LoadValid_out=1 during DONE only.
REQ-023 Writes: LoadData_out unchanged, LoadValid_out stays 0.
REQ-024 Stall_out = (IDLE & (MemRead_in|MemWrite_in)) | ACCESS; low in DONE so EX/MEM advances at the end of DONE.
REQ-025 DONE: unconditional return to IDLE; no new request issued in DONE (prevents re-issue of the same instruction).
REQ-026 Minimum latency: detect cycle + 1 ACCESS cycle = 2 stall cycles; N-cycle ack delay gives N+1 stall cycles.
REQ-027 MemAck_in outside ACCESS shall be ignored.
REQ-028 Non-memory instructions: Stall_out=0, MemReq_out=0, no state change.

Reset
REQ-029 rst=1 at any edge, including mid-ACCESS: state IDLE; MemReq_out, MemWe_out, LoadValid_out, Err_out=0; MemAddr_out, MemWdata_out, LoadData_out=0; timeout counter=0.
REQ-030 Stall_out while rst=1 follows REQ-024 with state=IDLE.

Configuration
REQ-031 Macro MEM_TIMEOUT_EN defined: 8-bit counter cleared on ACCESS entry, incremented each ACCESS cycle without ack; reaching TIMEOUT_CYCLES goes to DONE, LoadData_out<=0, LoadValid_out=0, Err_out pulses 1 cycle during DONE.
REQ-032 MEM_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, Err_out tied 0.
REQ-033 Ack on the expiry cycle: ack wins, no error.

Structure
REQ-034 Package mem_ctrl_pkg: FSM state encoding (2 bits), TIMEOUT_CYCLES default, counter width constant.
REQ-035 Sub-module mem_timeout_cnt (clear, enable, expired) instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-036 Load, Addr_in=0x100, ack on first ACCESS cycle with 0xDEADBEEF -> Stall_out 2 cycles, LoadData_out=0xDEADBEEF, LoadValid_out pulses once.
REQ-037 Store 0x12345678 to 0x40, ack after 3 ACCESS cycles -> MemWe_out=1, MemWdata_out=0x12345678, 4 stall cycles, no LoadValid_out.
REQ-038 Back-to-back load then store -> DONE between them, exactly two MemReq_out bursts, no re-issue.
REQ-039 rst asserted in 2nd ACCESS cycle -> next cycle IDLE, MemReq_out=0, all outputs 0.
REQ-040 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> DONE after 4 ACCESS cycles, Err_out 1 pulse, LoadData_out=0.
REQ-041 MemRead_in=MemWrite_in=1 -> write issued, no load pulse; stray MemAck_in in IDLE ignored.
